russian_peasant_unsigned_divider_8: RTL and testbench

RUSSIAN_PEASANT_UNSIGNED_DIVIDER_8 -- requirements
Module: russian_peasant_unsigned_divider_8

---
 rtl/russian_peasant_unsigned_divider_8.sv | 171 +++++++++++++++++
 tb/tb_russian_peasant_unsigned_divider_8.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/russian_peasant_unsigned_divider_8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : russian_peasant_unsigned_divider_8
// Description : Sequential 8-bit / 4-bit unsigned divider. It makes one
//               restoring shift/subtract step per clock, starting with the
//               dividend MSB, and takes 8 iterations per division.
//               Optional feature macro: RP_DIV_ZERO_DETECT_EN. When it is
//               defined, a zero divisor skips the iterations and sets
//               div_by_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module russian_peasant_unsigned_divider_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  // Working registers for the division in progress
  logic [7:0] dvd_q;    // latched dividend, shifted left one bit per step
  logic [3:0] dvs_q;    // latched divisor
  logic [3:0] rem_q;    // partial remainder
  logic [7:0] quo_q;    // quotient bits collected so far
  logic [2:0] cnt_q;    // index of the dividend bit being processed

  // Combinational result of one iteration
  logic [4:0] trial;
  logic       fits;
  logic [3:0] rem_sub;
  logic [3:0] rem_step;
  logic [7:0] quo_step;

  // High when the divisor presented with start is zero and the
  // zero-divisor shortcut is enabled
  logic       zero_in;

`ifdef RP_DIV_ZERO_DETECT_EN
  assign zero_in = (divisor == 4'd0);
`else
  assign zero_in = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // One restoring-division step: bring down the next bit and subtract if it fits.
  // When the subtraction is taken the difference is below the divisor, so it
  // always fits in 4 bits. Wrapping 4-bit subtraction gives the right answer.
  always_comb begin
    trial    = {rem_q, dvd_q[7]};
    fits     = (trial >= {1'b0, dvs_q});
    rem_sub  = trial[3:0] - dvs_q;
    rem_step = fits ? rem_sub : trial[3:0];
    quo_step = {quo_q[6:0], fits};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = zero_in ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_q == 3'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q     <= 8'd0;
      dvs_q     <= 4'd0;
      rem_q     <= 4'd0;
      quo_q     <= 8'd0;
      cnt_q     <= 3'd0;
      quotient  <= 8'd0;
      remainder <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= 4'd0;
            quo_q <= 8'd0;
            cnt_q <= 3'd7;
            if (zero_in) begin
              // The shortcut result matches what the iterations would give
              quotient  <= 8'hFF;
              remainder <= dividend[3:0];
            end
          end
        end
        RUN: begin
          dvd_q <= {dvd_q[6:0], 1'b0};
          rem_q <= rem_step;
          quo_q <= quo_step;
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            quotient  <= quo_step;
            remainder <= rem_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef RP_DIV_ZERO_DETECT_EN
  logic dz_q;

  // Zero-divisor flag: it is set by the shortcut and cleared by a normal
  // completion. It holds until the next entry into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dz_q <= 1'b0;
    end else if (state == IDLE && start) begin
      if (zero_in) begin
        dz_q <= 1'b1;
      end
    end else if (state == RUN && cnt_q == 3'd0) begin
      dz_q <= 1'b0;
    end
  end

  assign div_by_zero = dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_russian_peasant_unsigned_divider_8.sv
`timescale 1ns/1ps
`default_nettype none
module tb_russian_peasant_unsigned_divider_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  russian_peasant_unsigned_divider_8 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

`ifdef RP_DIV_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         due;       // cycle count at which done must be seen
    int         busy_len;  // number of sampled cycles with busy high
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer division. A zero divisor behaves as defined for the block.
  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b, input int c);
    exp_t e;
    if (b == 4'd0) begin
      e.q  = 8'hFF;
      e.r  = a[3:0];
      e.dz = ZD;
      e.due      = ZD ? c + 1 : c + 9;
      e.busy_len = ZD ? 1 : 9;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
      e.due      = c + 9;
      e.busy_len = 9;
    end
    return e;
  endfunction

  // Monitor: compares every done pulse against the scoreboard and checks that results hold between pulses
  initial begin
    int         busy_run  = 0;
    int         exp_busy  = 9;
    logic       done_prev = 1'b0;
    logic [7:0] lq  = 8'd0;
    logic [3:0] lr  = 4'd0;
    logic       ldz = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_run  = 0;
        done_prev = 1'b0;
        lq = 8'd0; lr = 4'd0; ldz = 1'b0;
      end else begin
        if (busy) begin
          busy_run++;
        end else if (busy_run != 0) begin
          chk("busy_len", busy_run, exp_busy);
          busy_run = 0;
        end
        if (done) begin
          chk("done_width", {31'd0, done_prev}, 32'd0);
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("done_cycle", cyc, e.due);
            chk("quotient", {24'd0, quotient}, {24'd0, e.q});
            chk("remainder", {28'd0, remainder}, {28'd0, e.r});
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
            exp_busy = e.busy_len;
            lq = e.q; lr = e.r; ldz = e.dz;
          end
        end else begin
          chk("hold_q", {24'd0, quotient}, {24'd0, lq});
          chk("hold_r", {28'd0, remainder}, {28'd0, lr});
          chk("hold_dz", {31'd0, div_by_zero}, {31'd0, ldz});
        end
        done_prev = done;
      end
    end
  end

  // Waits for IDLE and keeps the inputs busy with random values and ignored start requests
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      start    = 1'($urandom);
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=1 expected 0 within 50 cycles");
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [3:0] b);
    wait_idle();
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b, cyc));
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  int order[4096];

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", {24'd0, quotient}, 32'd0);
    chk("rst_r", {28'd0, remainder}, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(8'd225, 4'd15);
    issue(8'd5, 4'd9);
    issue(8'hFF, 4'd1);
    issue(8'hA7, 4'd0);

    // Start held high through RUN and DONE: a second division is accepted only after the return to IDLE
    wait_idle();
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    sb.push_back(model(8'd200, 4'd7, cyc));
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
    end
    @(negedge clk);
    dividend = 8'd37;
    divisor  = 4'd6;
    sb.push_back(model(8'd37, 4'd6, cyc));
    @(negedge clk);
    start = 1'b0;

    // Reset during the fourth RUN cycle abandons the division
    wait_idle();
    start    = 1'b1;
    dividend = 8'h5A;
    divisor  = 4'd6;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_q", {24'd0, quotient}, 32'd0);
    chk("arst_r", {28'd0, remainder}, 32'd0);
    chk("arst_dz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(8'd100, 4'd3);

    // All 4096 operand pairs, in shuffled order
    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(i, 0);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] p;
      p = 12'(order[i]);
      issue(p[11:4], p[3:0]);
    end

    // Drain outstanding results
    wait_idle();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
